// File: rtl/reg_wb_pkg.sv
// Shared encodings for the register writeback stage: writeback sources,
// load types and the writeback FSM states.
package reg_wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2,
    WB_NONE = 2'd3
  } wb_src_e;

  typedef enum logic [2:0] {
    LT_LW     = 3'd0,
    LT_LB     = 3'd1,
    LT_LBU    = 3'd2,
    LT_LH     = 3'd3,
    LT_LHU    = 3'd4,
    LT_LWL    = 3'd5,
    LT_LWR    = 3'd6,
    LT_LW_ALT = 3'd7
  } load_type_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WRITE    = 2'd2
  } state_e;

endpackage

// File: rtl/reg_wb_load_align.sv
// Combinational load-data alignment: byte/halfword extraction with sign or
// zero extension, and the unaligned LWL/LWR merge with the old register value.
module load_align
  import reg_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            i_load_type,
  input  logic [1:0]            i_addr_lo,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic [DATA_WIDTH-1:0] i_old_rt,
  output logic [DATA_WIDTH-1:0] o_load_data
);

  logic [DATA_WIDTH-1:0] w_ones;
  logic [DATA_WIDTH-1:0] w_byte_shift;
  logic [DATA_WIDTH-1:0] w_half_shift;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [5:0]            w_lo_bits;
  logic [5:0]            w_lwl_shift;
  logic [5:0]            w_lwl_keep;
  logic [DATA_WIDTH-1:0] w_lwl;
  logic [DATA_WIDTH-1:0] w_lwr;

  assign w_ones       = '1;
  assign w_lo_bits    = {1'b0, i_addr_lo, 3'b000};
  assign w_byte_shift = i_mem_rdata >> w_lo_bits;
  assign w_half_shift = i_mem_rdata >> {i_addr_lo[1], 4'b0000};
  assign w_byte       = w_byte_shift[7:0];
  assign w_half       = w_half_shift[15:0];

  // LWL shifts the loaded bytes up by 8*(3-k) and keeps the old low 24-8k bits;
  // a shift of 32 clears the old part entirely, giving the full word for k=3.
  assign w_lwl_shift = {1'b0, ~i_addr_lo, 3'b000};
  assign w_lwl_keep  = w_lo_bits + 6'd8;
  assign w_lwl       = (i_mem_rdata << w_lwl_shift) | (i_old_rt & (w_ones >> w_lwl_keep));
  assign w_lwr       = (i_mem_rdata >> w_lo_bits) | (i_old_rt & ~(w_ones >> w_lo_bits));

  // NOTE: o_load_data gets a default before the case so no latch is inferred.
  always_comb begin
    o_load_data = i_mem_rdata;
    case (load_type_e'(i_load_type))
      LT_LB:   o_load_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      LT_LBU:  o_load_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      LT_LH:   o_load_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      LT_LHU:  o_load_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
      LT_LWL:  o_load_data = w_lwl;
      LT_LWR:  o_load_data = w_lwr;
      default: o_load_data = i_mem_rdata;
    endcase
  end

endmodule

// File: rtl/reg_wb.sv
// Register writeback stage: accepts a writeback request, waits for load data
// when needed, and issues a single registered register-file write.
module reg_wb
  import reg_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            wb_src,
  input  logic [2:0]            load_type,
  input  logic [1:0]            addr_lo,
  input  logic [ADDR_WIDTH-1:0] dest,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] link_pc,
  input  logic [DATA_WIDTH-1:0] old_rt,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  wen,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done
);

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic                  r_wen;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [2:0]            r_load_type;
  logic [1:0]            r_addr_lo;
  logic [DATA_WIDTH-1:0] r_old_rt;

  state_e                w_state_next;
  logic                  w_wen_next;
  logic                  w_done_next;
  logic [DATA_WIDTH-1:0] w_wdata_next;
  logic                  w_latch_dest;
  logic                  w_capture_load;
  logic [DATA_WIDTH-1:0] w_load_data;

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .i_load_type (r_load_type),
    .i_addr_lo   (r_addr_lo),
    .i_mem_rdata (mem_rdata),
    .i_old_rt    (r_old_rt),
    .o_load_data (w_load_data)
  );

  // Write data only moves when a write will actually be issued, so wdata holds
  // its last value for dest=0 and wb_src=none requests.
  always_comb begin
    w_state_next   = r_state;
    w_wen_next     = 1'b0;
    w_done_next    = 1'b0;
    w_wdata_next   = r_wdata;
    w_latch_dest   = 1'b0;
    w_capture_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          case (wb_src_e'(wb_src))
            WB_ALU, WB_LINK: begin
              w_latch_dest = 1'b1;
              w_state_next = ST_WRITE;
              w_done_next  = 1'b1;
              w_wen_next   = (dest != '0);
              if (dest != '0)
                w_wdata_next = (wb_src_e'(wb_src) == WB_LINK) ? link_pc : alu_result;
            end
            WB_MEM: begin
              w_latch_dest   = 1'b1;
              w_capture_load = 1'b1;
              w_state_next   = ST_WAIT_MEM;
            end
            default: w_done_next = 1'b1;
          endcase
        end
      end
      ST_WAIT_MEM: begin
        if (mem_valid) begin
          w_state_next = ST_WRITE;
          w_done_next  = 1'b1;
          w_wen_next   = (r_waddr != '0);
          if (r_waddr != '0)
            w_wdata_next = w_load_data;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_waddr     <= '0;
      r_wen       <= 1'b0;
      r_done      <= 1'b0;
      r_wdata     <= '0;
      r_load_type <= '0;
      r_addr_lo   <= '0;
      r_old_rt    <= '0;
    end else begin
      r_state <= w_state_next;
      r_wen   <= w_wen_next;
      r_done  <= w_done_next;
      r_wdata <= w_wdata_next;
      if (w_latch_dest)
        r_waddr <= dest;
      if (w_capture_load) begin
        r_load_type <= load_type;
        r_addr_lo   <= addr_lo;
        r_old_rt    <= old_rt;
      end
    end
  end

  assign waddr = r_waddr;
  assign wen   = r_wen;
  assign wdata = r_wdata;
  assign done  = r_done;
  assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_reg_wb.sv
// Directed bench for reg_wb: ALU/LINK/MEM writebacks, load alignment, stalls,
// dest=0 and no-write requests, and asynchronous reset behaviour.
module tb_reg_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  wb_src;
  logic [2:0]  load_type;
  logic [1:0]  addr_lo;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] link_pc;
  logic [31:0] old_rt;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic [4:0]  waddr;
  logic        wen;
  logic [31:0] wdata;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_wdata;

  always #5 clk = ~clk;

  reg_wb dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .wb_src     (wb_src),
    .load_type  (load_type),
    .addr_lo    (addr_lo),
    .dest       (dest),
    .alu_result (alu_result),
    .link_pc    (link_pc),
    .old_rt     (old_rt),
    .mem_valid  (mem_valid),
    .mem_rdata  (mem_rdata),
    .waddr      (waddr),
    .wen        (wen),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " wen"},  32'(wen),  32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  // ALU or LINK request; returns to idle after the single write cycle.
  task automatic do_reg(input logic [1:0] src, input logic [4:0] d, input logic [31:0] val,
                        input string tag);
    start = 1'b1; wb_src = src; dest = d;
    if (src == 2'd2) begin link_pc = val; alu_result = 32'h0BAD_0BAD; end
    else begin alu_result = val; link_pc = 32'h0BAD_0BAD; end
    tick();
    start = 1'b0;
    if (d != 5'd0) last_wdata = val;
    check({tag, " wen"},   32'(wen),   (d != 5'd0) ? 32'd1 : 32'd0);
    check({tag, " done"},  32'(done),  32'd1);
    check({tag, " waddr"}, 32'(waddr), 32'(d));
    check({tag, " wdata"}, wdata,      last_wdata);
    tick();
    check_idle({tag, " after"});
  endtask

  // MEM request; load controls and old_rt are scrambled after start to
  // confirm they were latched.
  task automatic do_mem(input logic [2:0] lt, input logic [1:0] lo, input logic [31:0] old,
                        input logic [31:0] mem, input logic [4:0] d, input logic [31:0] exp,
                        input string tag);
    start = 1'b1; wb_src = 2'd1; load_type = lt; addr_lo = lo; old_rt = old; dest = d;
    tick();
    start = 1'b0; load_type = ~lt; addr_lo = ~lo; old_rt = ~old; dest = 5'd30;
    check({tag, " wait busy"}, 32'(busy), 32'd1);
    check({tag, " wait wen"},  32'(wen),  32'd0);
    mem_valid = 1'b1; mem_rdata = mem;
    tick();
    mem_valid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    last_wdata = exp;
    check({tag, " wen"},   32'(wen),   32'd1);
    check({tag, " done"},  32'(done),  32'd1);
    check({tag, " waddr"}, 32'(waddr), 32'(d));
    check({tag, " wdata"}, wdata,      exp);
    tick();
    check_idle({tag, " after"});
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; wb_src = 2'd0; load_type = 3'd0; addr_lo = 2'd0;
    dest = 5'd0; alu_result = '0; link_pc = '0; old_rt = '0; mem_valid = 1'b0;
    mem_rdata = '0; last_wdata = '0;
    #2;
    check("reset wen",   32'(wen),   32'd0);
    check("reset done",  32'(done),  32'd0);
    check("reset busy",  32'(busy),  32'd0);
    check("reset waddr", 32'(waddr), 32'd0);
    check("reset wdata", wdata,      32'd0);
    tick(); tick();
    rst = 1'b1;

    // First start right after release is accepted.
    do_reg(2'd0, 5'd5,  32'h1234_5678, "alu");
    do_reg(2'd2, 5'd31, 32'h0040_0008, "link");

    do_mem(3'd1, 2'd2, 32'h0,         32'h80FF_7F01, 5'd3,  32'hFFFF_FFFF, "lb");
    do_mem(3'd2, 2'd2, 32'h0,         32'h80FF_7F01, 5'd3,  32'h0000_00FF, "lbu");
    do_mem(3'd1, 2'd0, 32'h0,         32'h80FF_7F01, 5'd3,  32'h0000_0001, "lb0");
    do_mem(3'd3, 2'd2, 32'h0,         32'h80FF_7F01, 5'd4,  32'hFFFF_80FF, "lh");
    do_mem(3'd4, 2'd1, 32'h0,         32'h80FF_7F01, 5'd4,  32'h0000_7F01, "lhu");
    do_mem(3'd0, 2'd3, 32'h0,         32'hCAFE_F00D, 5'd6,  32'hCAFE_F00D, "lw");
    do_mem(3'd7, 2'd1, 32'h0,         32'h0102_0304, 5'd6,  32'h0102_0304, "lt7");
    do_mem(3'd5, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 5'd8,  32'h3344_CCDD, "lwl1");
    do_mem(3'd6, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 5'd8,  32'hAA11_2233, "lwr1");
    do_mem(3'd5, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 5'd8,  32'h44BB_CCDD, "lwl0");
    do_mem(3'd5, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 5'd8,  32'h1122_3344, "lwl3");
    do_mem(3'd6, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 5'd8,  32'h1122_3344, "lwr0");
    do_mem(3'd6, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 5'd8,  32'hAABB_CC11, "lwr3");

    // dest=0: done pulses, no write, wdata holds.
    do_reg(2'd0, 5'd0, 32'h5555_AAAA, "alu d0");

    // wb_src=none: done pulses, stays idle, nothing else moves.
    start = 1'b1; wb_src = 2'd3; dest = 5'd12;
    tick();
    start = 1'b0;
    check("none wen",   32'(wen),   32'd0);
    check("none done",  32'(done),  32'd1);
    check("none busy",  32'(busy),  32'd0);
    check("none wdata", wdata,      last_wdata);
    tick();
    check_idle("none after");

    // mem_valid while idle is ignored.
    mem_valid = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_valid = 1'b0;
    check_idle("stray mem_valid");

    // Stall with a second start injected while waiting.
    start = 1'b1; wb_src = 2'd1; load_type = 3'd0; addr_lo = 2'd0; dest = 5'd9;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin start = 1'b1; wb_src = 2'd0; dest = 5'd7; alu_result = 32'h9999_9999; end
      else start = 1'b0;
      tick();
      check($sformatf("stall busy %0d", i), 32'(busy), 32'd1);
      check($sformatf("stall wen %0d", i),  32'(wen),  32'd0);
    end
    start = 1'b0;
    mem_valid = 1'b1; mem_rdata = 32'hCAFE_BABE;
    tick();
    mem_valid = 1'b0;
    check("stall wen",   32'(wen),   32'd1);
    check("stall waddr", 32'(waddr), 32'd9);
    check("stall wdata", wdata,      32'hCAFE_BABE);
    tick();
    check_idle("stall after");
    check("stall single write", 32'(wen), 32'd0);

    // Asynchronous reset in WAIT_MEM aborts the load.
    start = 1'b1; wb_src = 2'd1; load_type = 3'd0; dest = 5'd4;
    tick();
    start = 1'b0;
    check("rst pre busy",  32'(busy),  32'd1);
    check("rst pre waddr", 32'(waddr), 32'd4);
    #2 rst = 1'b0;
    #1;
    check("rst mid waddr", 32'(waddr), 32'd0);
    check("rst mid wdata", wdata,      32'd0);
    check("rst mid busy",  32'(busy),  32'd0);
    check("rst mid wen",   32'(wen),   32'd0);
    tick();
    rst = 1'b1;
    mem_valid = 1'b1; mem_rdata = 32'h1357_9BDF;
    tick();
    mem_valid = 1'b0;
    check_idle("rst release");
    check("rst release wdata", wdata, 32'd0);
    tick();
    check("rst release wen2", 32'(wen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
